// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: keeps one fetch outstanding on the instruction bus and
// buffers up to DEPTH {pc, instr} pairs for execute, with redirect flush.
module fetch_prefetch_queue #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 'h200,
  parameter int                PC_STEP  = 4
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         redirect,
  input  logic [ADDR_W-1:0]            redirect_pc,
  output logic [ADDR_W-1:0]            bus_addr,
  output logic                         bus_ren,
  input  logic                         bus_busy,
  input  logic [DATA_W-1:0]            bus_rdata,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_instr,
  output logic [ADDR_W-1:0]            out_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              inflight_q, inflight_d;
  logic              discard_q, discard_d;
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] pc_mem_q    [DEPTH];
  logic [DATA_W-1:0] instr_mem_q [DEPTH];

  logic complete;
  logic push;
  logic pop;
  logic has_room;

  assign complete  = inflight_q & ~bus_busy;
  assign has_room  = (count_q != CW'(DEPTH));
  assign push      = complete & ~discard_q & ~redirect;
  assign out_valid = (count_q != '0) & ~redirect;
  assign pop       = out_valid & out_ready;

  assign bus_ren   = inflight_q;
  assign bus_addr  = req_addr_q;
  assign out_instr = instr_mem_q[head_q];
  assign out_pc    = pc_mem_q[head_q];
  assign count     = count_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;

    if (redirect) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc;
      if (inflight_q) begin
        // Held request must finish on the bus; its data is dropped later.
        if (complete) begin
          inflight_d = 1'b0;
          discard_d  = 1'b0;
        end else begin
          discard_d  = 1'b1;
        end
      end else begin
        inflight_d = 1'b1;
        req_addr_d = redirect_pc;
        discard_d  = 1'b0;
      end
    end else begin
      if (complete) begin
        inflight_d = 1'b0;
        discard_d  = 1'b0;
        if (!discard_q) begin
          tail_d     = tail_q + PW'(1);
          fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
        end
      end else if (!inflight_q && has_room) begin
        inflight_d = 1'b1;
        req_addr_d = fetch_pc_q;
      end

      if (pop) head_d = head_q + PW'(1);

      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      inflight_q <= 1'b0;
      discard_q  <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[tail_q]    <= fetch_pc_q;
      instr_mem_q[tail_q] <= bus_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: cycle-exact fetch, fill, redirect,
// wrap and reset scenarios with hand-computed expectations.
module tb_fetch_prefetch_queue;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] bus_addr;
  logic        bus_ren;
  logic        bus_busy;
  logic [31:0] bus_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  count;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_pc;

  fetch_prefetch_queue dut (
    .CLK(CLK), .nRST(nRST), .redirect(redirect), .redirect_pc(redirect_pc),
    .bus_addr(bus_addr), .bus_ren(bus_ren), .bus_busy(bus_busy), .bus_rdata(bus_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .count(count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    case (a)
      32'h200: instr_of = 32'h11;
      32'h204: instr_of = 32'h22;
      32'h208: instr_of = 32'h33;
      default: instr_of = a ^ 32'hDEAD_0000;
    endcase
  endfunction

  always_comb bus_rdata = instr_of(bus_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reset asserted across two edges; released just after an edge (cycle 0).
  task automatic do_reset(input logic rdy);
    nRST = 1'b0;
    redirect = 1'b0;
    bus_busy = 1'b0;
    out_ready = rdy;
    step();
    step();
    nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    bus_busy = 1'b0;
    out_ready = 1'b1;
    #2 nRST = 1'b0;
    step();
    chk("rst_ren", {31'd0, bus_ren}, 32'd0);
    chk("rst_addr", bus_addr, 32'h200);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_instr", out_instr, 32'd0);

    // Zero-wait streaming: one instruction every two cycles.
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s_ren", {31'd0, bus_ren}, 32'd1);
      chk("s_addr", bus_addr, 32'h200 + 32'(4*i));
      step();
      chk("s_valid", {31'd0, out_valid}, 32'd1);
      chk("s_pc", out_pc, 32'h200 + 32'(4*i));
      chk("s_instr", out_instr, instr_of(32'h200 + 32'(4*i)));
      chk("s_ren_gap", {31'd0, bus_ren}, 32'd0);
    end

    // Fill to DEPTH with execute stalled.
    do_reset(1'b0);
    begin
      int comps = 0;
      for (int i = 0; i < 12; i++) begin
        step();
        if (bus_ren && !bus_busy) comps++;
      end
      chk("fill_comps", 32'(comps), 32'd4);
    end
    chk("fill_count", {29'd0, count}, 32'd4);
    chk("fill_ren", {31'd0, bus_ren}, 32'd0);
    chk("fill_head", out_pc, 32'h200);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pop_count", {29'd0, count}, 32'd3);
    chk("pop_head", out_pc, 32'h204);
    step();
    chk("refill_ren", {31'd0, bus_ren}, 32'd1);
    chk("refill_addr", bus_addr, 32'h210);
    step();
    chk("refill_count", {29'd0, count}, 32'd4);

    // Redirect while a request is held by wait states.
    do_reset(1'b1);
    step(); step(); step(); step();
    bus_busy = 1'b1;
    step();
    chk("held_ren", {31'd0, bus_ren}, 32'd1);
    chk("held_addr", bus_addr, 32'h208);
    step();
    redirect = 1'b1;
    redirect_pc = 32'h1000;
    #1;
    chk("rd_valid", {31'd0, out_valid}, 32'd0);
    step();
    redirect = 1'b0;
    chk("hold_ren", {31'd0, bus_ren}, 32'd1);
    chk("hold_addr", bus_addr, 32'h208);
    step();
    chk("hold2_addr", bus_addr, 32'h208);
    bus_busy = 1'b0;
    step();
    chk("drop_ren", {31'd0, bus_ren}, 32'd0);
    chk("drop_valid", {31'd0, out_valid}, 32'd0);
    chk("drop_count", {29'd0, count}, 32'd0);
    step();
    chk("new_ren", {31'd0, bus_ren}, 32'd1);
    chk("new_addr", bus_addr, 32'h1000);
    step();
    chk("new_valid", {31'd0, out_valid}, 32'd1);
    chk("new_pc", out_pc, 32'h1000);
    chk("new_instr", out_instr, 32'h1000 ^ 32'hDEAD_0000);
    out_ready = 1'b0;

    // Redirect coinciding with a completion and a pop.
    step();
    chk("rc_ren", {31'd0, bus_ren}, 32'd1);
    chk("rc_count", {29'd0, count}, 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h2000;
    out_ready = 1'b1;
    #1;
    chk("rc_valid", {31'd0, out_valid}, 32'd0);
    step();
    redirect = 1'b0;
    chk("rc_count0", {29'd0, count}, 32'd0);
    chk("rc_valid0", {31'd0, out_valid}, 32'd0);
    chk("rc_ren0", {31'd0, bus_ren}, 32'd0);
    step();
    chk("rc_ren1", {31'd0, bus_ren}, 32'd1);
    chk("rc_addr", bus_addr, 32'h2000);
    step();
    chk("rc_pc", out_pc, 32'h2000);

    // Redirect with nothing in flight issues on the next cycle.
    redirect = 1'b1;
    redirect_pc = 32'h3000;
    #1;
    chk("ri_valid", {31'd0, out_valid}, 32'd0);
    step();
    redirect = 1'b0;
    chk("ri_ren", {31'd0, bus_ren}, 32'd1);
    chk("ri_addr", bus_addr, 32'h3000);
    chk("ri_count", {29'd0, count}, 32'd0);
    step();
    chk("ri_pc", out_pc, 32'h3000);

    // Push and pop together at count=2 across pointer wrap.
    do_reset(1'b0);
    step(); step(); step(); step();
    exp_pc = 32'h200;
    for (int i = 0; i < 10; i++) begin
      chk("pp_count", {29'd0, count}, 32'd2);
      out_ready = bus_ren & ~bus_busy;
      if (bus_ren) begin
        chk("pp_pc", out_pc, exp_pc);
        chk("pp_instr", out_instr, instr_of(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end
      step();
    end
    chk("pp_popped", exp_pc, 32'h214);
    chk("pp_count_end", {29'd0, count}, 32'd2);

    // Reset mid-fetch with three entries queued.
    out_ready = 1'b0;
    step();
    step();
    bus_busy = 1'b1;
    step();
    chk("mr_count", {29'd0, count}, 32'd3);
    chk("mr_ren", {31'd0, bus_ren}, 32'd1);
    chk("mr_addr", bus_addr, 32'h220);
    nRST = 1'b0;
    #1;
    chk("mr_async_count", {29'd0, count}, 32'd0);
    chk("mr_async_ren", {31'd0, bus_ren}, 32'd0);
    step();
    chk("mr_count0", {29'd0, count}, 32'd0);
    chk("mr_ren0", {31'd0, bus_ren}, 32'd0);
    nRST = 1'b1;
    bus_busy = 1'b0;
    step();
    chk("mr_ren1", {31'd0, bus_ren}, 32'd1);
    chk("mr_addr1", bus_addr, 32'h200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
